// File: rtl/ticker_pkg.sv
// Shared types and default limit terms for the const_ticker family.
package ticker_pkg;

  typedef enum logic [1:0] {
    STOPPED   = 2'd0,
    RUNNING   = 2'd1,
    SATURATED = 2'd2
  } tick_state_e;

  localparam int unsigned DEF_BASE_A = 10;
  localparam int unsigned DEF_BASE_B = 20;
  localparam int unsigned DEF_OFFSET = 7;

  function automatic int unsigned ticker_limit(input int unsigned a, input int unsigned b,
                                               input int unsigned c);
    return a + b + c;
  endfunction

endpackage

// File: rtl/ticker_event_slot.sv
// Single-entry limit-event slot: valid/ready hold, sticky overflow, event counter.
module ticker_event_slot (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       evt_i,
  input  logic       evt_ready_i,
  output logic       evt_valid_o,
  output logic [7:0] evt_count_o,
  output logic       overflow_o
);

  logic       r_valid;
  logic [7:0] r_count;
  logic       r_overflow;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_valid    <= 1'b0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (evt_i) begin
        // A new event keeps the slot full; it is only lost if the old one was not taken.
        r_valid <= 1'b1;
        r_count <= r_count + 8'd1;
        if (r_valid && !evt_ready_i) r_overflow <= 1'b1;
      end else if (r_valid && evt_ready_i) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign evt_valid_o = r_valid;
  assign evt_count_o = r_count;
  assign overflow_o  = r_overflow;

endmodule

// File: rtl/const_ticker.sv
// Start/stop counter that wraps or saturates at a constant limit and posts limit events.
module const_ticker
  import ticker_pkg::*;
#(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned BASE_A   = DEF_BASE_A,
  parameter int unsigned BASE_B   = DEF_BASE_B,
  parameter int unsigned OFFSET   = DEF_OFFSET,
  parameter int unsigned STEP     = 1,
  parameter bit          SATURATE = 1'b0
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start_i,
  input  logic             stop_i,
  input  logic             en_i,
  input  logic             clear_i,
  input  logic             evt_ready_i,
  output logic [WIDTH-1:0] count_o,
  output logic [WIDTH-1:0] limit_o,
  output logic [1:0]       state_o,
  output logic             evt_valid_o,
  output logic [7:0]       evt_count_o,
  output logic             overflow_o
);

  localparam int unsigned LIMIT = ticker_limit(BASE_A, BASE_B, OFFSET);

  if ((STEP < 1) || (STEP > LIMIT) || (longint'(LIMIT) >= (longint'(1) << WIDTH))) begin : g_bad_params
    $fatal(1, "const_ticker: require 1 <= STEP <= LIMIT and LIMIT < 2**WIDTH");
  end

  localparam logic [WIDTH:0]   LIMIT_X = (WIDTH+1)'(LIMIT);
  localparam logic [WIDTH:0]   STEP_X  = (WIDTH+1)'(STEP);
  localparam logic [WIDTH-1:0] LIMIT_W = WIDTH'(LIMIT);

  tick_state_e      r_state;
  tick_state_e      w_state_nxt;
  logic [WIDTH-1:0] r_count;
  logic [WIDTH-1:0] w_count_nxt;
  logic [WIDTH:0]   w_sum;
  logic             w_evt;

  always_comb begin
    w_sum       = {1'b0, r_count} + STEP_X;
    w_state_nxt = r_state;
    w_count_nxt = r_count;
    w_evt       = 1'b0;
    case (r_state)
      STOPPED: begin
        if (start_i && !stop_i) w_state_nxt = RUNNING;
      end
      RUNNING: begin
        if (stop_i) begin
          w_state_nxt = STOPPED;
        end else if (en_i && !clear_i) begin
          if (w_sum < LIMIT_X) begin
            w_count_nxt = w_sum[WIDTH-1:0];
          end else if (SATURATE) begin
            w_count_nxt = LIMIT_W;
            w_state_nxt = SATURATED;
            w_evt       = 1'b1;
          end else begin
            w_count_nxt = WIDTH'(w_sum - LIMIT_X);
            w_evt       = 1'b1;
          end
        end
      end
      SATURATED: begin
        if (stop_i)       w_state_nxt = STOPPED;
        else if (clear_i) w_state_nxt = RUNNING;
      end
      default: w_state_nxt = STOPPED;
    endcase
    // Clear overrides any count update in every state, even when stop decides the state.
    if (clear_i) w_count_nxt = '0;
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_state <= STOPPED;
      r_count <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_count <= w_count_nxt;
    end
  end

  ticker_event_slot u_event_slot (
    .clock      (clock),
    .reset_n    (reset_n),
    .evt_i      (w_evt),
    .evt_ready_i(evt_ready_i),
    .evt_valid_o(evt_valid_o),
    .evt_count_o(evt_count_o),
    .overflow_o (overflow_o)
  );

  assign count_o = r_count;
  assign limit_o = LIMIT_W;
  assign state_o = r_state;

endmodule

// File: tb/tb_const_ticker.sv
// Self-checking bench: three const_ticker configurations against an arithmetic reference model.
module tb_const_ticker;

  logic clock = 1'b0;
  logic reset_n, start_i, stop_i, en_i, clear_i, evt_ready_i;

  logic [7:0] c0, c1, c2, l0, l1, l2, e0, e1, e2;
  logic [1:0] s0, s1, s2;
  logic       v0, v1, v2, o0, o1, o2;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  always #5 clock = ~clock;

  const_ticker u_d0 (
    .clock(clock), .reset_n(reset_n), .start_i(start_i), .stop_i(stop_i), .en_i(en_i),
    .clear_i(clear_i), .evt_ready_i(evt_ready_i), .count_o(c0), .limit_o(l0), .state_o(s0),
    .evt_valid_o(v0), .evt_count_o(e0), .overflow_o(o0));

  const_ticker #(.STEP(5)) u_d1 (
    .clock(clock), .reset_n(reset_n), .start_i(start_i), .stop_i(stop_i), .en_i(en_i),
    .clear_i(clear_i), .evt_ready_i(evt_ready_i), .count_o(c1), .limit_o(l1), .state_o(s1),
    .evt_valid_o(v1), .evt_count_o(e1), .overflow_o(o1));

  const_ticker #(.SATURATE(1'b1)) u_d2 (
    .clock(clock), .reset_n(reset_n), .start_i(start_i), .stop_i(stop_i), .en_i(en_i),
    .clear_i(clear_i), .evt_ready_i(evt_ready_i), .count_o(c2), .limit_o(l2), .state_o(s2),
    .evt_valid_o(v2), .evt_count_o(e2), .overflow_o(o2));

  // Reference model: one entry per instance, plain integers.
  localparam int LIM = 10 + 20 + 7;
  int p_step[3] = '{1, 5, 1};
  int p_sat[3]  = '{0, 0, 1};
  int m_cnt[3], m_st[3], m_val[3], m_ec[3], m_ovf[3];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_step();
    for (int k = 0; k < 3; k++) begin
      int nc, ns, sum;
      bit evt;
      nc = m_cnt[k]; ns = m_st[k]; evt = 0;
      if (!reset_n) begin
        m_cnt[k] = 0; m_st[k] = 0; m_val[k] = 0; m_ec[k] = 0; m_ovf[k] = 0;
      end else begin
        if (m_st[k] == 0) begin
          if (start_i && !stop_i) ns = 1;
        end else if (m_st[k] == 1) begin
          if (stop_i) ns = 0;
          else if (en_i && !clear_i) begin
            sum = m_cnt[k] + p_step[k];
            if (sum < LIM) nc = sum;
            else if (p_sat[k] == 0) begin nc = sum - LIM; evt = 1; end
            else begin nc = LIM; ns = 2; evt = 1; end
          end
        end else begin
          if (stop_i) ns = 0;
          else if (clear_i) ns = 1;
        end
        if (clear_i) nc = 0;
        if (evt) begin
          if (m_val[k] && !evt_ready_i) m_ovf[k] = 1;
          m_val[k] = 1;
          m_ec[k]  = (m_ec[k] + 1) % 256;
        end else if (m_val[k] && evt_ready_i) begin
          m_val[k] = 0;
        end
        m_cnt[k] = nc; m_st[k] = ns;
      end
    end
  endtask

  task automatic cmp_inst(input int k, input logic [7:0] c, input logic [1:0] s, input logic v,
                          input logic [7:0] e, input logic o, input logic [7:0] l);
    check($sformatf("d%0d count", k), c, m_cnt[k]);
    check($sformatf("d%0d state", k), s, m_st[k]);
    check($sformatf("d%0d evt_valid", k), v, m_val[k]);
    check($sformatf("d%0d evt_count", k), e, m_ec[k]);
    check($sformatf("d%0d overflow", k), o, m_ovf[k]);
    check($sformatf("d%0d limit", k), l, LIM);
  endtask

  task automatic cycle();
    model_step();
    @(posedge clock);
    #1;
    cmp_inst(0, c0, s0, v0, e0, o0, l0);
    cmp_inst(1, c1, s1, v1, e1, o1, l1);
    cmp_inst(2, c2, s2, v2, e2, o2, l2);
  endtask

  task automatic drive(input logic rn, input logic st, input logic sp, input logic en,
                       input logic cl, input logic rdy);
    reset_n = rn; start_i = st; stop_i = sp; en_i = en; clear_i = cl; evt_ready_i = rdy;
  endtask

  initial begin
    drive(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    #1 check("limit during reset", l0, 37);
    cycle(); cycle();
    check("reset count", c0, 0);
    check("reset state", s0, 0);
    check("reset evt_count", e0, 0);

    // start together with stop stays STOPPED
    drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1); cycle();
    check("start+stop state", s0, 0);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1); cycle();
    check("start state", s0, 1);
    check("start count", c0, 0);

    // default wrap, STEP=5 wrap, saturate
    drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    for (int k = 1; k <= 38; k++) begin
      cycle();
      if (k < 37) check("d0 ramp", c0, k);
      if (k == 37) begin
        check("d0 wrap count", c0, 0);
        check("d0 wrap valid", v0, 1);
        check("d0 wrap evt_count", e0, 1);
        check("d2 sat count", c2, 37);
        check("d2 sat state", s2, 2);
        check("d2 sat evt_count", e2, 1);
      end
      if (k == 8) begin
        check("d1 step5 wrap count", c1, 3);
        check("d1 step5 valid", v1, 1);
      end
      if (k == 38) begin
        check("d2 en ignored", c2, 37);
        check("d0 valid taken", v0, 0);
      end
    end
    for (int k = 0; k < 19; k++) cycle();
    check("d0 at 20", c0, 20);
    drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1); cycle();
    check("clear+en count", c0, 0);
    check("clear+en no event", e0, 1);
    check("d2 clear count", c2, 0);
    check("d2 clear state", s2, 1);

    // stop at 12 holds the count
    drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    for (int k = 0; k < 12; k++) cycle();
    drive(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1); cycle();
    check("stop state", s0, 0);
    check("stop count", c0, 12);
    drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1); cycle();
    check("stopped hold", c0, 12);

    // two wraps without ready -> overflow
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0); cycle();
    drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 62; k++) cycle();
    check("ovf count", c0, 0);
    check("ovf evt_count", e0, 3);
    check("ovf flag", o0, 1);
    check("ovf valid", v0, 1);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1); cycle();
    check("ready clears valid", v0, 0);
    check("overflow sticky", o0, 1);

    // reset with event pending at count 20
    drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 57; k++) cycle();
    check("pre-reset count", c0, 20);
    check("pre-reset valid", v0, 1);
    drive(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0); cycle();
    check("rst count", c0, 0);
    check("rst state", s0, 0);
    check("rst valid", v0, 0);
    check("rst evt_count", e0, 0);
    check("rst overflow", o0, 0);
    drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0); cycle();
    check("post-reset start", s0, 1);

    // randomized traffic against the model
    for (int k = 0; k < 3000; k++) begin
      drive(($urandom_range(63) != 0), ($urandom_range(3) == 0), ($urandom_range(9) == 0),
            ($urandom_range(3) != 0), ($urandom_range(11) == 0), $urandom_range(1) == 1);
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
